// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM feeding the IF/ID pipeline register
module fetch_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            IF_ID_write,
  input  logic            IF_ID_flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] IF_ID_pc,
  output logic [31:0]     IF_ID_inst,
  output logic            IF_ID_valid
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t state, state_n;
  logic [XLEN-1:0] pc, pc_n, ifpc_n;
  logic [31:0] buf_q, buf_n, inst_n, word;
  logic valid_n, stall, xfer, flush;
  always_comb begin
    stall = !pc_write || !IF_ID_write;
    flush = IF_ID_flush && IF_ID_write;
    xfer = !stall && (state == HOLD || (state == WAIT && imem_rvalid));
    word = state == HOLD ? buf_q : imem_rdata;
    buf_n = state == WAIT && imem_rvalid && stall ? imem_rdata : buf_q;
    inst_n = branch_taken || flush ? NOP : xfer ? word : IF_ID_inst;
    valid_n = branch_taken || flush ? 1'b0 : xfer ? 1'b1 : IF_ID_valid;
    ifpc_n = !branch_taken && !flush && xfer ? pc : IF_ID_pc;
    pc_n = branch_taken ? branch_target & ~XLEN'(3) : !flush && xfer ? pc + XLEN'(4) : pc;
    state_n = branch_taken ? (state == REQ || ((state == WAIT || state == DRAIN) && !imem_rvalid) ? DRAIN : REQ)
            : state == IDLE ? REQ
            : state == REQ ? WAIT
            : xfer ? REQ
            : state == WAIT && imem_rvalid ? HOLD
            : state == DRAIN && imem_rvalid ? REQ
            : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      buf_q <= '0;
      IF_ID_pc <= '0;
      IF_ID_inst <= NOP;
      IF_ID_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      buf_q <= buf_n;
      IF_ID_pc <= ifpc_n;
      IF_ID_inst <= inst_n;
      IF_ID_valid <= valid_n;
    end
  end
  assign imem_req = state == REQ;
  assign imem_addr = pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table, directed and randomized checks of fetch_unit against a reference model
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic r, pw, iw, fl, bt;
    logic [31:0] tgt;
    logic rv;
    logic [31:0] rd;
    logic req;
    logic [31:0] addr, pc, inst;
    logic vld;
  } vec_t;
  logic clk = 0;
  logic rst, pc_write, IF_ID_write, IF_ID_flush, branch_taken, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;
  logic imem_req, req1, IF_ID_valid, valid1;
  logic [31:0] imem_addr, addr1, IF_ID_pc, pc1, IF_ID_inst, inst1;
  int checks = 0, errors = 0, cnt = 0;
  logic m_idle, m_issue, m_out, m_disc, m_hb, m_v;
  logic [31:0] m_buf, m_pc, m_ifpc, m_inst;
  vec_t tbl[$];
  always #5 clk = ~clk;
  fetch_unit u0 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(IF_ID_pc), .IF_ID_inst(IF_ID_inst), .IF_ID_valid(IF_ID_valid)
  );
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .IF_ID_flush(IF_ID_flush), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req1), .imem_addr(addr1), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_ID_pc(pc1), .IF_ID_inst(inst1), .IF_ID_valid(valid1)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic m_reset;
    m_idle = 1; m_issue = 0; m_out = 0; m_disc = 0; m_hb = 0; m_buf = 0;
    m_pc = 0; m_ifpc = 0; m_inst = NOP; m_v = 0;
  endtask
  task automatic m_step;
    logic stall, got, have, take;
    logic [31:0] w;
    if (rst) begin
      m_reset();
      return;
    end
    stall = !pc_write || !IF_ID_write;
    got = m_out && imem_rvalid;
    have = m_hb || (got && !m_disc);
    w = m_hb ? m_buf : imem_rdata;
    take = have && !stall;
    if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_inst = NOP; m_v = 0; m_hb = 0; m_idle = 0;
      m_disc = m_issue || (m_out && !imem_rvalid);
      m_out = m_disc;
      m_issue = !m_disc;
    end else begin
      if (IF_ID_flush && IF_ID_write) begin
        m_inst = NOP; m_v = 0;
      end else if (take) begin
        m_ifpc = m_pc; m_inst = w; m_v = 1; m_pc = m_pc + 4;
      end
      if (m_idle) begin
        m_idle = 0; m_issue = 1;
      end else if (m_issue) begin
        m_issue = 0; m_out = 1;
      end else if (got) begin
        m_out = 0;
        if (m_disc || take) begin
          m_disc = 0; m_issue = 1;
        end else begin
          m_hb = 1; m_buf = imem_rdata;
        end
      end else if (m_hb && take) begin
        m_hb = 0; m_issue = 1;
      end
    end
  endtask
  initial begin
    rst = 1; pc_write = 1; IF_ID_write = 1; IF_ID_flush = 0; branch_taken = 0;
    branch_target = 0; imem_rvalid = 0; imem_rdata = 0;
    tbl.push_back('{1,1,1,0,0,0,0,0,                0,0,0,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,                1,0,0,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,0,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,1,32'hA,            1,4,0,32'hA,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,0,32'hA,1});
    tbl.push_back('{0,1,1,0,0,0,1,32'hB,            1,8,4,32'hB,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,4,32'hB,1});
    tbl.push_back('{0,1,1,0,0,0,1,32'hC,            1,32'hC,8,32'hC,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,8,32'hC,1});
    tbl.push_back('{0,0,0,0,0,0,1,32'h1234_5678,    0,0,8,32'hC,1});
    tbl.push_back('{0,0,0,0,0,0,0,0,                0,0,8,32'hC,1});
    tbl.push_back('{0,0,0,0,0,0,0,0,                0,0,8,32'hC,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                1,32'h10,32'hC,32'h1234_5678,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,32'hC,32'h1234_5678,1});
    tbl.push_back('{0,1,1,0,1,32'h103,0,0,          0,0,32'hC,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,1,32'hDEAD,         1,32'h100,32'hC,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,32'hC,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,1,32'hAAA,          1,32'h104,32'h100,32'hAAA,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,32'h100,32'hAAA,1});
    tbl.push_back('{0,1,0,1,0,0,0,0,                0,0,32'h100,32'hAAA,1});
    tbl.push_back('{0,1,1,1,0,0,0,0,                0,0,32'h100,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,1,32'hBBB,          1,32'h108,32'h104,32'hBBB,1});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,32'h104,32'hBBB,1});
    tbl.push_back('{0,1,1,1,0,0,1,32'hCCC,          1,32'h108,32'h104,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,32'h104,NOP,0});
    tbl.push_back('{1,1,1,0,0,0,0,0,                0,0,0,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,1,32'hEEE,          1,0,0,NOP,0});
    tbl.push_back('{0,1,1,0,0,0,0,0,                0,0,0,NOP,0});
    foreach (tbl[i]) begin
      rst = tbl[i].r; pc_write = tbl[i].pw; IF_ID_write = tbl[i].iw; IF_ID_flush = tbl[i].fl;
      branch_taken = tbl[i].bt; branch_target = tbl[i].tgt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rd;
      tick();
      chk($sformatf("row%0d req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("row%0d addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("row%0d if_pc", i), IF_ID_pc, tbl[i].pc);
      chk($sformatf("row%0d if_inst", i), IF_ID_inst, tbl[i].inst);
      chk($sformatf("row%0d if_valid", i), {31'b0, IF_ID_valid}, {31'b0, tbl[i].vld});
    end
    rst = 1; pc_write = 1; IF_ID_write = 1; IF_ID_flush = 0; branch_taken = 0; imem_rvalid = 0;
    tick();
    chk("wrap rst req", {31'b0, req1}, 0);
    rst = 0;
    tick();
    chk("wrap first addr", addr1, 32'hFFFF_FFFC);
    chk("wrap first req", {31'b0, req1}, 1);
    tick();
    imem_rvalid = 1; imem_rdata = 32'h77;
    tick();
    imem_rvalid = 0;
    chk("wrap if_pc", pc1, 32'hFFFF_FFFC);
    chk("wrap if_inst", inst1, 32'h77);
    chk("wrap req", {31'b0, req1}, 1);
    chk("wrap next addr", addr1, 32'h0);
    rst = 1;
    m_reset();
    tick();
    for (int t = 0; t < 3000; t++) begin
      rst = $urandom_range(0, 199) == 0;
      pc_write = $urandom_range(0, 3) != 0;
      IF_ID_write = $urandom_range(0, 3) != 0;
      IF_ID_flush = $urandom_range(0, 7) == 0;
      branch_taken = $urandom_range(0, 15) == 0;
      branch_target = $urandom;
      imem_rdata = $urandom;
      imem_rvalid = 0;
      if (cnt > 0) begin
        cnt--;
        imem_rvalid = cnt == 0;
      end else if (!m_out && $urandom_range(0, 7) == 0) imem_rvalid = 1;
      if (m_issue) cnt = $urandom_range(1, 3);
      if (rst) cnt = 0;
      m_step();
      tick();
      chk("rand req", {31'b0, imem_req}, {31'b0, m_issue});
      if (m_issue) chk("rand addr", imem_addr, m_pc);
      chk("rand if_pc", IF_ID_pc, m_ifpc);
      chk("rand if_inst", IF_ID_inst, m_inst);
      chk("rand if_valid", {31'b0, IF_ID_valid}, {31'b0, m_v});
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
